// File: rtl/pixel_fetch_machine.sv
// Fetches the 3x3 neighbourhood of every interior pixel over the AS_N/ACK_N bus, then pulses pixel_valid
// and waits for wr_done. Optional READ_TIMEOUT_EN adds an ACK watchdog with a sticky err output.
module pixel_fetch_machine #(
  parameter int          ADDR_W    = 32,
  parameter int          IMG_W     = 8,
  parameter int          IMG_H     = 8,
  parameter int unsigned BASE_ADDR = 0,
  parameter int          TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              ACK_N,
  input  logic [31:0]       DATA_IN,
  input  logic              wr_done,
  output logic              AS_N,
  output logic              RD_N,
  output logic              stop_n,
  output logic [ADDR_W-1:0] ADDR,
  output logic [71:0]       window,
  output logic              pixel_valid,
  output logic              in_init,
  output logic              done,
  output logic [2:0]        state_out
`ifdef READ_TIMEOUT_EN
  ,
  output logic              err
`endif
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ADDR    = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_TERM    = 3'd3;
  localparam logic [2:0] S_VALID   = 3'd4;
  localparam logic [2:0] S_WAIT_WR = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;

  localparam int RC_W = 16;

  logic [2:0]      state;
  logic [RC_W-1:0] row;
  logic [RC_W-1:0] col;
  logic [3:0]      k;
  logic [1:0]      dr;
  logic [1:0]      dc;
  logic [ADDR_W-1:0] addr_calc;
  logic            bus_active;
  logic            to_fire;
  logic            unused_bits;

  assign dr = 2'(k / 4'd3);
  assign dc = 2'(k % 4'd3);

  // Neighbour address relative to the centre pixel; wraps at ADDR_W bits.
  assign addr_calc = ADDR_W'(BASE_ADDR)
                   + (ADDR_W'(row) + ADDR_W'(dr) - ADDR_W'(1)) * ADDR_W'(IMG_W)
                   + ADDR_W'(col) + ADDR_W'(dc) - ADDR_W'(1);

  assign bus_active  = (state == S_ADDR) || (state == S_WAIT);
  assign AS_N        = !bus_active;
  assign RD_N        = !bus_active;
  assign stop_n      = (state != S_WAIT);
  assign ADDR        = bus_active ? addr_calc : '0;
  assign pixel_valid = (state == S_VALID);
  assign in_init     = (state == S_IDLE);
  assign done        = (state == S_DONE);
  assign state_out   = state;

  assign unused_bits = ^{DATA_IN[31:8], (TIMEOUT > 0)};

`ifdef READ_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  logic [TO_W-1:0] to_cnt;

  assign to_fire = (state == S_WAIT) && ACK_N && (to_cnt == TO_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt <= '0;
      err    <= 1'b0;
    end else begin
      if (state == S_ADDR)
        to_cnt <= '0;
      else if (state == S_WAIT)
        to_cnt <= to_cnt + 1'b1;
      if (state == S_IDLE && start)
        err <= 1'b0;
      else if (to_fire)
        err <= 1'b1;
    end
  end
`else
  assign to_fire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      row    <= RC_W'(1);
      col    <= RC_W'(1);
      k      <= 4'd0;
      window <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_ADDR;
            row   <= RC_W'(1);
            col   <= RC_W'(1);
            k     <= 4'd0;
          end
        end
        S_ADDR: state <= S_WAIT;
        S_WAIT: begin
          if (!ACK_N) begin
            window[{k, 3'b000} +: 8] <= DATA_IN[7:0];
            state <= S_TERM;
          end else if (to_fire) begin
            state <= S_DONE;
          end
        end
        S_TERM: begin
          if (k == 4'd8) begin
            state <= S_VALID;
          end else begin
            k     <= k + 4'd1;
            state <= S_ADDR;
          end
        end
        S_VALID: state <= S_WAIT_WR;
        S_WAIT_WR: begin
          if (wr_done) begin
            k <= 4'd0;
            if (col == RC_W'(IMG_W - 2) && row == RC_W'(IMG_H - 2)) begin
              state <= S_DONE;
            end else if (col == RC_W'(IMG_W - 2)) begin
              col   <= RC_W'(1);
              row   <= row + RC_W'(1);
              state <= S_ADDR;
            end else begin
              col   <= col + RC_W'(1);
              state <= S_ADDR;
            end
          end
        end
        S_DONE: if (!start) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_fetch_machine.sv
// Directed bench for pixel_fetch_machine on a 4x4 image with mem[a]=a; bus slave and writer modelled here.
module tb_pixel_fetch_machine;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        ACK_N = 1'b1;
  logic [31:0] DATA_IN = '0;
  logic        wr_done = 1'b0;
  logic        AS_N, RD_N, stop_n, pixel_valid, in_init, done;
  logic [31:0] ADDR;
  logic [71:0] window;
  logic [2:0]  state_out;
`ifdef READ_TIMEOUT_EN
  logic        err;
`endif

  pixel_fetch_machine #(
    .ADDR_W(32), .IMG_W(4), .IMG_H(4), .BASE_ADDR(0), .TIMEOUT(4)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .ACK_N(ACK_N), .DATA_IN(DATA_IN),
    .wr_done(wr_done), .AS_N(AS_N), .RD_N(RD_N), .stop_n(stop_n), .ADDR(ADDR),
    .window(window), .pixel_valid(pixel_valid), .in_init(in_init), .done(done),
    .state_out(state_out)
`ifdef READ_TIMEOUT_EN
    , .err(err)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Slave / writer model state
  logic        clr_cnt = 1'b0;
  logic        ack_never = 1'b0;
  int          delay_rd = -1;
  int          delay_cyc = 0;
  int          as_cnt = 0;
  int          cur_rd = 0;
  int          rd_total = 0;
  int          falls = 0;
  int          pv_cnt = 0;
  int          wdly = 0;
  logic [71:0] wins[$];

  always @(negedge clk) begin
    if (clr_cnt) begin
      falls = 0; pv_cnt = 0; rd_total = 0; wins.delete();
    end
    if (AS_N == 1'b0) begin
      if (as_cnt == 0) begin
        cur_rd = rd_total;
        rd_total++;
        falls++;
      end
      as_cnt++;
      if (!ack_never && as_cnt >= 2 + ((cur_rd == delay_rd) ? delay_cyc : 0)) begin
        ACK_N   = 1'b0;
        DATA_IN = ADDR;
      end
    end else begin
      as_cnt = 0;
      ACK_N  = 1'b1;
    end
    // Writer commits two cycles after each pixel_valid
    if (pixel_valid) begin
      pv_cnt++;
      wins.push_back(window);
      wdly = 2;
      wr_done = 1'b0;
    end else if (wdly > 0) begin
      wdly--;
      wr_done = (wdly == 0);
    end else begin
      wr_done = 1'b0;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clr();
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
  endtask

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int          r;
    int          c;
    logic [71:0] win;
  } vec_t;

  vec_t        tbl[4];
  logic [71:0] w;
  int          n;
  int          good;

  initial begin
    tbl[0] = '{1, 1, {8'd10, 8'd9,  8'd8,  8'd6,  8'd5, 8'd4, 8'd2, 8'd1, 8'd0}};
    tbl[1] = '{1, 2, {8'd11, 8'd10, 8'd9,  8'd7,  8'd6, 8'd5, 8'd3, 8'd2, 8'd1}};
    tbl[2] = '{2, 1, {8'd14, 8'd13, 8'd12, 8'd10, 8'd9, 8'd8, 8'd6, 8'd5, 8'd4}};
    tbl[3] = '{2, 2, {8'd15, 8'd14, 8'd13, 8'd11, 8'd10, 8'd9, 8'd7, 8'd6, 8'd5}};

    // Reset and idle with start low
    reset = 1'b1; start = 1'b0;
    tick(); tick();
    reset = 1'b0;
    clr();
    for (int i = 0; i < 10; i++) tick();
    chk("idle_in_init", in_init, 1);
    chk("idle_as_n", AS_N, 1);
    chk("idle_rd_n", RD_N, 1);
    chk("idle_stop_n", stop_n, 1);
    chk("idle_done", done, 0);
    chk("idle_state", state_out, 0);
    chk("idle_addr", ADDR, 0);
    chk("idle_window", window, 0);
    chk("idle_pv_count", pv_cnt, 0);

    // Full pass with zero-wait slave
    start = 1'b1;
    for (int i = 0; i < 200 && !pixel_valid; i++) tick();
    chk("wait_first_pv", pixel_valid, 1);
    chk("first_reads", falls, 9);
    chk("first_pv_count", pv_cnt, 1);
    chk("first_window", window, tbl[0].win);
    for (int i = 0; i < 2000 && !done; i++) tick();
    chk("wait_done", done, 1);
    chk("pass_pv_count", pv_cnt, 4);
    chk("pass_reads", falls, 36);
    chk("pass_windows", wins.size(), 4);
    for (int i = 0; i < 4; i++) begin
      w = (i < wins.size()) ? wins[i] : '0;
      chk($sformatf("window_r%0d_c%0d", tbl[i].r, tbl[i].c), w, tbl[i].win);
    end
    tick(); tick(); tick();
    chk("done_hold", done, 1);
    start = 1'b0;
    tick();
    chk("done_to_idle", state_out, 0);
    chk("done_in_init", in_init, 1);

    // ACK delayed 5 cycles on read k=4
    delay_rd = 4; delay_cyc = 5;
    clr();
    start = 1'b1;
    for (int i = 0; i < 100 && !(state_out == 3'd2 && ADDR == 32'd5); i++) tick();
    n = 0; good = 0;
    while (state_out == 3'd2 && n < 50) begin
      n++;
      if (stop_n == 1'b0 && ADDR == 32'd5) good++;
      tick();
    end
    chk("stall_cycles", n, 6);
    chk("stall_stable", good, 6);
    for (int i = 0; i < 100 && !pixel_valid; i++) tick();
    w = window;
    chk("stall_tap4", w[39:32], 5);
    reset = 1'b1; start = 1'b0; delay_rd = -1;
    tick(); tick();
    reset = 1'b0;

    // Reset during the third read's WAIT_ACK
    delay_rd = 2; delay_cyc = 60;
    clr();
    start = 1'b1;
    for (int i = 0; i < 100 && !(rd_total == 3 && state_out == 3'd2); i++) tick();
    chk("third_read_wait", stop_n, 0);
    reset = 1'b1;
    tick();
    chk("rst_as_n", AS_N, 1);
    chk("rst_rd_n", RD_N, 1);
    chk("rst_state", state_out, 0);
    chk("rst_window", window, 0);
    reset = 1'b0; start = 1'b0; delay_rd = -1;
    clr();
    start = 1'b1;
    for (int i = 0; i < 20 && AS_N; i++) tick();
    chk("restart_strobe", AS_N, 0);
    chk("restart_addr", ADDR, 0);
    reset = 1'b1; start = 1'b0;
    tick(); tick();
    reset = 1'b0;

`ifdef READ_TIMEOUT_EN
    ack_never = 1'b1;
    clr();
    start = 1'b1;
    for (int i = 0; i < 20 && state_out != 3'd2; i++) tick();
    n = 0;
    while (state_out == 3'd2 && n < 50) begin
      n++;
      tick();
    end
    chk("to_wait_cycles", n, 4);
    chk("to_err", err, 1);
    chk("to_done", done, 1);
    chk("to_as_n", AS_N, 1);
    start = 1'b0;
    tick();
    chk("to_idle", state_out, 0);
    chk("to_err_sticky", err, 1);
    start = 1'b1;
    tick();
    chk("to_err_clear", err, 0);
    ack_never = 1'b0;
    reset = 1'b1; start = 1'b0;
    tick();
    reset = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
